// File: rtl/alu_div_mod_seq_if.sv
// Start/done handshake and operand/result bus between the execute stage and the divider.
// The master is the execute stage; the slave is alu_div_mod_seq.
interface alu_div_mod_seq_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              is_mod;
    logic              is_32;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] c;

    modport master (
        output start, a, b, is_mod, is_32,
        input  busy, done, c
    );

    modport slave (
        input  start, a, b, is_mod, is_32,
        output busy, done, c
    );
endinterface

// File: rtl/alu_div_mod_seq.sv
// Iterative radix-2 restoring divider for eBPF BPF_DIV/BPF_MOD (ALU64 and ALU32).
// One quotient bit per cycle; divide-by-zero resolves without any RUN cycles.
module alu_div_mod_seq #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_div_mod_seq_if.slave   bus
);
    localparam int HALF_W = DATA_W / 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] b_q;
    logic              mod_q;
    logic              w32_q;
    logic [DATA_W-1:0] c_q;

    logic [DATA_W-1:0] a_eff;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   rem_sh;
    logic              fits;
    logic [DATA_W-1:0] rem_nxt;
    logic [DATA_W-1:0] q_nxt;
    logic [DATA_W-1:0] res_raw;
    logic [DATA_W-1:0] result;

    always_comb begin
        a_eff = bus.is_32 ? {{HALF_W{1'b0}}, bus.a[HALF_W-1:0]} : bus.a;
        b_eff = bus.is_32 ? {{HALF_W{1'b0}}, bus.b[HALF_W-1:0]} : bus.b;

        // rem < b_q always holds, so the restored difference fits in DATA_W bits
        rem_sh  = {rem, q[DATA_W-1]};
        fits    = rem_sh >= {1'b0, b_q};
        rem_nxt = fits ? (rem_sh[DATA_W-1:0] - b_q) : rem_sh[DATA_W-1:0];
        q_nxt   = {q[DATA_W-2:0], fits};

        res_raw = mod_q ? rem_nxt : q_nxt;
        result  = w32_q ? {{HALF_W{1'b0}}, res_raw[HALF_W-1:0]} : res_raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            b_q   <= '0;
            mod_q <= 1'b0;
            w32_q <= 1'b0;
            c_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mod_q <= bus.is_mod;
                        w32_q <= bus.is_32;
                        b_q   <= b_eff;
                        rem   <= '0;
                        if (b_eff == '0) begin
                            c_q   <= bus.is_mod ? a_eff : '0;
                            state <= DONE;
                        end else begin
                            // ALU32 dividend sits in the top half so its MSB shifts out first
                            q     <= bus.is_32 ? {bus.a[HALF_W-1:0], {HALF_W{1'b0}}} : bus.a;
                            cnt   <= bus.is_32 ? CNT_W'(HALF_W - 1) : CNT_W'(DATA_W - 1);
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    if (cnt == '0) begin
                        c_q   <= result;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.c    = c_q;
endmodule

// File: tb/tb_alu_div_mod_seq.sv
// Self-checking bench for alu_div_mod_seq: directed scenarios plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_alu_div_mod_seq;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_div_mod_seq_if #(.DATA_W(64)) bus ();

    alu_div_mod_seq #(.DATA_W(64), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_result(input logic [63:0] ra, input logic [63:0] rb,
                                               input logic rm, input logic r32);
        logic [63:0] ae;
        logic [63:0] be;
        ae = r32 ? (ra & 64'h0000_0000_FFFF_FFFF) : ra;
        be = r32 ? (rb & 64'h0000_0000_FFFF_FFFF) : rb;
        if (be == 64'd0) return rm ? ae : 64'd0;
        return rm ? (ae % be) : (ae / be);
    endfunction

    function automatic int ref_latency(input logic [63:0] rb, input logic r32);
        logic [63:0] be;
        be = r32 ? (rb & 64'h0000_0000_FFFF_FFFF) : rb;
        if (be == 64'd0) return 1;
        return r32 ? 33 : 65;
    endfunction

    // Issues one operation, scrambles operands after acceptance, and watches until one cycle after done.
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v, input logic tm, input logic t32,
                          output logic [63:0] res, output int lat, output int ndone,
                          output logic busy_ok, output logic c_stable);
        logic [63:0] c0;
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.is_mod = tm; bus.is_32 = t32; bus.start = 1'b1;
        c0 = bus.c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom};
        bus.is_mod = ~tm; bus.is_32 = ~t32;
        lat = -1; ndone = 0; busy_ok = 1'b1; c_stable = 1'b1; res = '0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    res = bus.c;
                end
            end
            if (lat < 0 && !bus.busy) busy_ok = 1'b0;
            if (lat < 0 && bus.c !== c0) c_stable = 1'b0;
            if (lat >= 0 && k == lat + 1) begin
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_mod = 1'b0; bus.is_32 = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.c !== 64'd0) begin fails++; $display("FAIL reset_c: got %h expected 0", bus.c); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_div64();
        logic [63:0] r; int lat; int nd; logic bok; logic cs;
        run_op(64'd100, 64'd7, 1'b0, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'd14) begin fails++; $display("FAIL div64_c: got %0d expected 14", r); end
        tests++; if (lat !== 65) begin fails++; $display("FAIL div64_latency: got %0d expected 65", lat); end
        tests++; if (nd !== 1) begin fails++; $display("FAIL div64_done_count: got %0d expected 1", nd); end
        tests++; if (bok !== 1'b1) begin fails++; $display("FAIL div64_busy: got %b expected 1", bok); end
        tests++; if (cs !== 1'b1) begin fails++; $display("FAIL div64_c_stable: got %b expected 1", cs); end
    endtask

    task automatic test_mod64_extremes();
        logic [63:0] r; int lat; int nd; logic bok; logic cs;
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b1, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'hF) begin fails++; $display("FAIL mod64_max_c: got %h expected f", r); end
        tests++; if (lat !== 65) begin fails++; $display("FAIL mod64_latency: got %0d expected 65", lat); end
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL div64_by1_c: got %h expected ffffffffffffffff", r); end
    endtask

    task automatic test_alu32();
        logic [63:0] r; int lat; int nd; logic bok; logic cs;
        run_op(64'hDEAD_BEEF_0000_0010, 64'hFFFF_FFFF_0000_0003, 1'b0, 1'b1, r, lat, nd, bok, cs);
        tests++; if (r !== 64'h5) begin fails++; $display("FAIL alu32_div_c: got %h expected 5", r); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL alu32_latency: got %0d expected 33", lat); end
        run_op(64'hDEAD_BEEF_0000_0010, 64'hFFFF_FFFF_0000_0003, 1'b1, 1'b1, r, lat, nd, bok, cs);
        tests++; if (r !== 64'h1) begin fails++; $display("FAIL alu32_mod_c: got %h expected 1", r); end
    endtask

    task automatic test_div_by_zero();
        logic [63:0] r; int lat; int nd; logic bok; logic cs;
        run_op(64'h1234, 64'd0, 1'b0, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'd0) begin fails++; $display("FAIL dbz_div_c: got %h expected 0", r); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        run_op(64'h1234, 64'd0, 1'b1, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'h1234) begin fails++; $display("FAIL dbz_mod_c: got %h expected 1234", r); end
        run_op(64'hABCD_EF01_2345_6789, 64'h1_0000_0000, 1'b1, 1'b1, r, lat, nd, bok, cs);
        tests++; if (r !== 64'h2345_6789) begin fails++; $display("FAIL dbz32_mod_c: got %h expected 23456789", r); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL dbz32_latency: got %0d expected 1", lat); end
    endtask

    task automatic test_start_while_busy();
        int nd; int first_at; int second_at; logic [63:0] c1; logic [63:0] c2;
        nd = 0; first_at = -1; second_at = -1; c1 = '0; c2 = '0;
        @(negedge clk);
        bus.a = 64'd100; bus.b = 64'd7; bus.is_mod = 1'b0; bus.is_32 = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 135; k++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (first_at < 0) begin first_at = k; c1 = bus.c; end
                else if (second_at < 0) begin second_at = k; c2 = bus.c; end
            end
            if (k == 10 || k == 66) begin bus.a = 64'd50; bus.b = 64'd5; bus.start = 1'b1; end
            if (k == 11 || k == 67) bus.start = 1'b0;
        end
        tests++; if (first_at !== 65) begin fails++; $display("FAIL busy_ignore_done_at: got %0d expected 65", first_at); end
        tests++; if (c1 !== 64'd14) begin fails++; $display("FAIL busy_ignore_c: got %0d expected 14", c1); end
        tests++; if (second_at !== 131) begin fails++; $display("FAIL reissue_done_at: got %0d expected 131", second_at); end
        tests++; if (c2 !== 64'd10) begin fails++; $display("FAIL reissue_c: got %0d expected 10", c2); end
        tests++; if (nd !== 2) begin fails++; $display("FAIL busy_done_count: got %0d expected 2", nd); end
    endtask

    task automatic test_back_to_back();
        int first_at; int second_at; logic [63:0] c1; logic [63:0] c2;
        first_at = -1; second_at = -1; c1 = '0; c2 = '0;
        @(negedge clk);
        bus.a = 64'd1000; bus.b = 64'd9; bus.is_mod = 1'b1; bus.is_32 = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.a = 64'd777; bus.b = 64'd10; bus.is_mod = 1'b0;
        for (int k = 1; k <= 135; k++) begin
            @(negedge clk);
            if (bus.done) begin
                if (first_at < 0) begin first_at = k; c1 = bus.c; end
                else if (second_at < 0) begin second_at = k; c2 = bus.c; end
            end
            if (k == 67) bus.start = 1'b0;
        end
        tests++; if (first_at !== 65 || c1 !== 64'd1) begin fails++; $display("FAIL held_first: got at %0d c=%0d expected at 65 c=1", first_at, c1); end
        tests++; if (second_at !== 131 || c2 !== 64'd77) begin fails++; $display("FAIL held_second: got at %0d c=%0d expected at 131 c=77", second_at, c2); end
    endtask

    task automatic test_reset_mid_op();
        int nd; logic [63:0] r; int lat; logic bok; logic cs;
        nd = 0;
        @(negedge clk);
        bus.a = 64'd1000; bus.b = 64'd3; bus.is_mod = 1'b0; bus.is_32 = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.c !== 64'd0) begin
            fails++; $display("FAIL async_reset: got busy=%b done=%b c=%h expected 0 0 0", bus.busy, bus.done, bus.c);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        tests++; if (nd !== 0) begin fails++; $display("FAIL post_reset_activity: got %0d cycles expected 0", nd); end
        run_op(64'd9, 64'd3, 1'b0, 1'b0, r, lat, nd, bok, cs);
        tests++; if (r !== 64'd3 || lat !== 65) begin fails++; $display("FAIL post_reset_div: got c=%0d at %0d expected c=3 at 65", r, lat); end
    endtask

    task automatic test_random();
        logic [63:0] ra; logic [63:0] rb; logic rm; logic r32;
        logic [63:0] r; int lat; int nd; logic bok; logic cs;
        logic [63:0] exp_r; int exp_lat;
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = 64'd0;
                1:       rb = 64'($urandom_range(1, 1000));
                2:       rb = {$urandom, $urandom};
                default: rb = {$urandom, 32'd0};
            endcase
            rm = 1'($urandom_range(0, 1));
            r32 = 1'($urandom_range(0, 1));
            exp_r = ref_result(ra, rb, rm, r32);
            exp_lat = ref_latency(rb, r32);
            run_op(ra, rb, rm, r32, r, lat, nd, bok, cs);
            tests++;
            if (r !== exp_r || lat !== exp_lat || nd !== 1 || bok !== 1'b1 || cs !== 1'b1) begin
                fails++;
                $display("FAIL random_%0d: a=%h b=%h mod=%b w32=%b got c=%h lat=%0d dones=%0d busy_ok=%b c_stable=%b expected c=%h lat=%0d",
                         i, ra, rb, rm, r32, r, lat, nd, bok, cs, exp_r, exp_lat);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_div64();
        test_mod64_extremes();
        test_alu32();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_div_mod_seq.md
Name: alu_div_mod_seq

Overview:
Iterative radix-2 restoring divider for the eBPF core ALU. It executes the BPF_DIV and BPF_MOD opcodes in both ALU64 and ALU32 forms. The single-cycle bitwise units (and/or/xor) cannot cover division, so this is the core's multi-cycle arithmetic unit. The execute stage drives it with a start/done handshake and stalls while busy is high.

Parameters:
DATA_W, 64, full operand/result width (ALU64 width); ALU32 mode uses the low DATA_W/2 bits
CNT_W, 7, iteration counter width, must satisfy 2^CNT_W > DATA_W

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; accepted only in IDLE
a  input  DATA_W  dividend (dst register value), sampled on accepted start
b  input  DATA_W  divisor (src register or imm), sampled on accepted start
is_mod  input  1  0 = quotient (DIV), 1 = remainder (MOD), sampled on accepted start
is_32  input  1  1 = ALU32 semantics, sampled on accepted start
busy  output  1  high in RUN and DONE; execute stage stalls while high
done  output  1  one-cycle pulse, c valid in the same cycle
c  output  DATA_W  result register; holds until the next result is written

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, c=0. The counter, remainder and quotient registers clear. In-flight operation is abandoned with no done pulse.
- Effective operands: if is_32, a_eff = zero-extend(a[31:0]) and b_eff = zero-extend(b[31:0]), and N = DATA_W/2. Otherwise a_eff=a, b_eff=b, N=DATA_W. Unsigned arithmetic only.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=0: remain in IDLE.
- IDLE, start=1, b_eff==0 (eBPF divide-by-zero rule): go to DONE. Result = a_eff if is_mod, else 0. No exception, no RUN cycles.
- IDLE, start=1, b_eff!=0: go to RUN. Load quotient shift reg = a_eff aligned so its MSB of N bits is shifted first. Remainder = 0, counter = N-1.
- RUN, each cycle: rem' = {rem, next dividend bit}. If rem' >= b_eff, subtract b_eff and shift 1 into the quotient, else shift 0. The compare/subtract is DATA_W+1 bits wide to avoid overflow.
- RUN, counter==0: go to DONE. Otherwise decrement the counter.
- DONE: done=1 for exactly one cycle. c is loaded with the result on entry to DONE: quotient or remainder, zero-extended to DATA_W in 32-bit mode (upper 32 bits = 0). Next state is always IDLE.
- Latency, accepted start at cycle T:
  - normal: done at T+N+1 (T+65 in 64-bit, T+33 in 32-bit)
  - divide-by-zero: done at T+1
- Throughput: a new start is accepted earliest in the cycle after done (IDLE).
- start while busy=1: ignored. No queueing, no effect on the in-flight operation or its sampled operands.
- Changing a/b/is_mod/is_32 after acceptance has no effect.
- c is only written on entry to DONE. It is stable in IDLE and RUN, and retains the last result across idle periods.
- 1-cycle start pulse and a held-high start behave identically. A held start re-issues in the cycle after done.

Test Plan:
- 64-bit DIV: a=100, b=7, is_mod=0, is_32=0, start at T -> busy high T+1..T+65, done pulse at T+65 only, c=14.
- 64-bit MOD extremes: a=0xFFFFFFFF_FFFFFFFF, b=0x10, is_mod=1 -> c=0xF at T+65. Repeat with DIV, b=1 -> c=0xFFFFFFFF_FFFFFFFF.
- ALU32 truncation: a=0xDEADBEEF_00000010, b=0xFFFFFFFF_00000003, is_32=1, DIV -> done at T+33, c=0x00000000_00000005. Same operands with MOD -> c=0x1.
- Divide-by-zero: a=0x1234, b=0, DIV -> done at T+1, c=0. MOD -> c=0x1234. In 32-bit mode, b=0x1_00000000 counts as zero -> MOD gives c=zero-extended a[31:0].
- Start while busy: second start with a=50, b=5 at T+10 during a 100/7 op -> only one done at T+65, c=14. A start issued at T+66 yields c=10 at T+131.
- Reset mid-operation: assert rst_n=0 at T+20 of a 64-bit DIV -> busy, done and c go to 0 asynchronously. After release, no done pulse appears, and a fresh 9/3 DIV completes with c=3.
